// File: rtl/risc16_pkg.sv
// Shared opcode, ALU-class, trap-cause and state definitions for the risc16 control path.
package risc16_pkg;

    localparam logic [3:0] OP_LD  = 4'h0;
    localparam logic [3:0] OP_ST  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_SLL = 4'h7;
    localparam logic [3:0] OP_SRL = 4'h8;
    localparam logic [3:0] OP_SLT = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hB;
    localparam logic [3:0] OP_BNE = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;

    localparam logic [1:0] ALUOP_R   = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_MEM = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StMem, StWb, StTrap
    } state_t;

    // mem_read / mem_write / reg_write are qualifiers; the sequencer gates them by state.
    typedef struct packed {
        logic       jump;
        logic       beq;
        logic       bne;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/risc16_decode.sv
// Combinational opcode decoder: control bundle plus illegal-opcode flag.
module risc16_decode
    import risc16_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal
);

    // Map each opcode to its control bundle; unlisted opcodes are illegal.
    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_LD: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_op     = ALUOP_MEM;
            end
            OP_ST: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_MEM;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLT: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_R;
            end
            OP_BEQ: begin
                ctrl.beq    = 1'b1;
                ctrl.alu_op = ALUOP_BR;
            end
            OP_BNE: begin
                ctrl.bne    = 1'b1;
                ctrl.alu_op = ALUOP_BR;
            end
            OP_JMP: ctrl.jump = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/risc16_ctrl_seq.sv
// Multi-cycle control sequencer for the risc16 datapath with memory handshakes and traps.
module risc16_ctrl_seq
    import risc16_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic [3:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             jump,
    output logic             beq,
    output logic             bne,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [1:0]       alu_op,
    output logic             ir_load,
    output logic             pc_en,
    output logic             busy,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    ctrl_t            dec_ctrl;
    logic             dec_illegal;
    logic [7:0]       tmo_q, tmo_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Output registers, loaded from the next state so every output is a flop.
    ctrl_t out_q, out_d;
    logic  ir_load_q, ir_load_d;
    logic  pc_en_q, pc_en_d;
    logic  busy_q, busy_d;
    logic  trap_q, trap_d;

    risc16_decode u_decode (
        .opcode  (opcode),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // Next-state logic, timeout counter, trap cause and retire counter.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        tmo_d   = tmo_q;
        cause_d = cause_q;
        count_d = count_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StFetch;
            StFetch:  if (imem_ready) state_d = StDecode;
            StDecode: begin
                ctrl_d = dec_ctrl;
                if (dec_illegal) begin
                    state_d = StTrap;
                    cause_d = TRAP_ILLEGAL;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                tmo_d   = '0;
                state_d = (ctrl_q.mem_read || ctrl_q.mem_write) ? StMem : StWb;
            end
            StMem: begin
                // A ready on the final allowed cycle still wins over the timeout.
                if (dmem_ready) begin
                    state_d = StWb;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = StTrap;
                    cause_d = TRAP_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StWb: begin
                count_d = count_q + 1'b1;
                state_d = halt_req ? StIdle : StFetch;
            end
            StTrap:   state_d = StTrap;
            default:  state_d = StIdle;
        endcase
    end

    // Output next values: controls only in EXEC/MEM/WB, strobes only in their own state.
    always_comb begin
        out_d     = '0;
        ir_load_d = (state_d == StFetch);
        pc_en_d   = (state_d == StWb);
        busy_d    = (state_d != StIdle) && (state_d != StTrap);
        trap_d    = (state_d == StTrap);
        if (state_d inside {StExec, StMem, StWb}) begin
            out_d.jump       = ctrl_d.jump;
            out_d.beq        = ctrl_d.beq;
            out_d.bne        = ctrl_d.bne;
            out_d.alu_src    = ctrl_d.alu_src;
            out_d.reg_dst    = ctrl_d.reg_dst;
            out_d.mem_to_reg = ctrl_d.mem_to_reg;
            out_d.alu_op     = ctrl_d.alu_op;
        end
        out_d.mem_read  = (state_d == StMem) && ctrl_d.mem_read;
        out_d.mem_write = (state_d == StMem) && ctrl_d.mem_write;
        out_d.reg_write = (state_d == StWb) && ctrl_d.reg_write;
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ctrl_q    <= '0;
            tmo_q     <= '0;
            cause_q   <= TRAP_NONE;
            count_q   <= '0;
            out_q     <= '0;
            ir_load_q <= 1'b0;
            pc_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            tmo_q     <= tmo_d;
            cause_q   <= cause_d;
            count_q   <= count_d;
            out_q     <= out_d;
            ir_load_q <= ir_load_d;
            pc_en_q   <= pc_en_d;
            busy_q    <= busy_d;
            trap_q    <= trap_d;
        end
    end

    assign jump        = out_q.jump;
    assign beq         = out_q.beq;
    assign bne         = out_q.bne;
    assign mem_read    = out_q.mem_read;
    assign mem_write   = out_q.mem_write;
    assign alu_src     = out_q.alu_src;
    assign reg_dst     = out_q.reg_dst;
    assign mem_to_reg  = out_q.mem_to_reg;
    assign reg_write   = out_q.reg_write;
    assign alu_op      = out_q.alu_op;
    assign ir_load     = ir_load_q;
    assign pc_en       = pc_en_q;
    assign busy        = busy_q;
    assign trap        = trap_q;
    assign trap_cause  = cause_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_risc16_ctrl_seq.sv
// Bench for risc16_ctrl_seq: per-cycle trace model plus literal checks on observed counts.
module tb_risc16_ctrl_seq;

    localparam int TMO   = 15;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        PH_IDLE, PH_FETCH, PH_DECODE, PH_EXEC, PH_MEM, PH_WB, PH_TRAP
    } ph_t;

    typedef struct packed {
        logic             jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg;
        logic             reg_write;
        logic [1:0]       alu_op;
        logic             ir_load, pc_en, busy, trap;
        logic [1:0]       trap_cause;
        logic [CNT_W-1:0] count;
    } outs_t;

    logic clk = 1'b0;
    logic rst_n, start, halt_req, imem_ready, dmem_ready;
    logic [3:0] opcode;
    logic jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write;
    logic [1:0] alu_op, trap_cause;
    logic ir_load, pc_en, busy, trap;
    logic [CNT_W-1:0] instr_count;

    risc16_ctrl_seq #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt_req    (halt_req),
        .opcode      (opcode),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .jump        (jump),
        .beq         (beq),
        .bne         (bne),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .alu_src     (alu_src),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_op      (alu_op),
        .ir_load     (ir_load),
        .pc_en       (pc_en),
        .busy        (busy),
        .trap        (trap),
        .trap_cause  (trap_cause),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    outs_t exp_o;
    ph_t exp_ph;
    logic exp_on;
    logic [3:0] cur_op;
    logic [CNT_W-1:0] model_count;
    logic [1:0] model_cause;
    int obs_busy, obs_pc_en, obs_reg_write, obs_mem_read, obs_mem_write, obs_trap;
    logic tr;

    // Expected outputs for one cycle spent in a given phase of an instruction.
    function automatic outs_t model(input ph_t ph, input logic [3:0] op,
                                    input logic [CNT_W-1:0] cnt, input logic [1:0] cause);
        outs_t e;
        logic is_ld, is_st, is_r, is_br;
        e = '0;
        is_ld = (op == 4'd0);
        is_st = (op == 4'd1);
        is_r  = (op >= 4'd2) && (op <= 4'd9);
        is_br = (op == 4'd11) || (op == 4'd12);
        e.count = cnt;
        case (ph)
            PH_FETCH:  begin e.ir_load = 1'b1; e.busy = 1'b1; end
            PH_DECODE: e.busy = 1'b1;
            PH_EXEC, PH_MEM, PH_WB: begin
                e.busy       = 1'b1;
                e.jump       = (op == 4'd13);
                e.beq        = (op == 4'd11);
                e.bne        = (op == 4'd12);
                e.alu_src    = is_ld || is_st;
                e.reg_dst    = is_r;
                e.mem_to_reg = is_ld;
                e.alu_op     = (is_ld || is_st) ? 2'b10 : (is_br ? 2'b01 : 2'b00);
                if (ph == PH_MEM) begin
                    e.mem_read  = is_ld;
                    e.mem_write = is_st;
                end
                if (ph == PH_WB) begin
                    e.pc_en     = 1'b1;
                    e.reg_write = is_ld || is_r;
                end
            end
            PH_TRAP: begin e.trap = 1'b1; e.trap_cause = cause; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic outs_t sample();
        outs_t a;
        a = '0;
        a.jump = jump; a.beq = beq; a.bne = bne; a.mem_read = mem_read;
        a.mem_write = mem_write; a.alu_src = alu_src; a.reg_dst = reg_dst;
        a.mem_to_reg = mem_to_reg; a.reg_write = reg_write; a.alu_op = alu_op;
        a.ir_load = ir_load; a.pc_en = pc_en; a.busy = busy; a.trap = trap;
        a.trap_cause = trap_cause; a.count = instr_count;
        return a;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            obs_busy      += int'(busy);
            obs_pc_en     += int'(pc_en);
            obs_reg_write += int'(reg_write);
            obs_mem_read  += int'(mem_read);
            obs_mem_write += int'(mem_write);
            obs_trap      += int'(trap);
        end
        if (exp_on && rst_n) begin
            n_vec++;
            if (sample() !== exp_o) begin
                n_fail++;
                $display("FAIL cycle_%s op=%h t=%0t: got %h required %h",
                         exp_ph.name(), cur_op, $time, sample(), exp_o);
            end
        end
    end

    task automatic lit(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic clr_obs();
        obs_busy = 0; obs_pc_en = 0; obs_reg_write = 0;
        obs_mem_read = 0; obs_mem_write = 0; obs_trap = 0;
    endtask

    // One clock: set the expectation for the phase now current and drive inputs for the next edge.
    task automatic cyc(input ph_t ph, input logic st, input logic im, input logic dm,
                       input logic hr);
        @(posedge clk);
        #1;
        exp_ph = ph;
        exp_o  = model(ph, cur_op, model_count, model_cause);
        exp_on = 1'b1;
        start = st; imem_ready = im; dmem_ready = dm; halt_req = hr;
    endtask

    task automatic do_reset();
        exp_on = 1'b0;
        rst_n = 1'b0;
        start = 1'b0; halt_req = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_count = '0;
        model_cause = 2'b00;
    endtask

    // One instruction from FETCH entry; halt_req is also raised in DECODE/EXEC, where it is ignored.
    task automatic run(input logic [3:0] op, input int fwait, input int mwait, input logic halt,
                       output logic trapped);
        logic got;
        trapped = 1'b0;
        cur_op = op;
        opcode = op;
        for (int i = 0; i <= fwait; i++) cyc(PH_FETCH, 1'b0, (i == fwait), 1'b0, 1'b0);
        cyc(PH_DECODE, 1'b0, 1'b0, 1'b0, 1'b1);
        if (op == 4'd10 || op >= 4'd14) begin
            trapped = 1'b1;
            model_cause = 2'b01;
            return;
        end
        cyc(PH_EXEC, 1'b0, 1'b0, 1'b0, 1'b1);
        if (op == 4'd0 || op == 4'd1) begin
            got = 1'b0;
            for (int j = 0; j < TMO; j++) begin
                cyc(PH_MEM, 1'b0, 1'b0, (j == mwait), 1'b0);
                if (j == mwait) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                trapped = 1'b1;
                model_cause = 2'b10;
                return;
            end
        end
        cyc(PH_WB, 1'b0, 1'b0, 1'b0, halt);
        model_count = model_count + 1'b1;
    endtask

    logic [3:0] ill_ops [3];

    initial begin
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; opcode = 4'd0;
        imem_ready = 1'b0; dmem_ready = 1'b0; exp_on = 1'b0; cur_op = 4'd0;
        model_count = '0; model_cause = 2'b00; exp_o = '0; exp_ph = PH_IDLE;
        ill_ops[0] = 4'hA; ill_ops[1] = 4'hE; ill_ops[2] = 4'hF;
        clr_obs();
        do_reset();
        repeat (3) cyc(PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a store's MEM phase clears everything at once.
        cur_op = 4'd1; opcode = 4'd1;
        cyc(PH_IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(PH_FETCH, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(PH_DECODE, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(PH_EXEC, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(PH_MEM, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        lit("mem_write_before_reset", int'(mem_write), 1);
        exp_on = 1'b0;
        rst_n = 1'b0;
        #1;
        lit("outputs_in_reset", int'(sample()), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_count = '0; model_cause = 2'b00;
        repeat (10) cyc(PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        lit("idle_busy", int'(busy), 0);
        lit("idle_count", int'(instr_count), 0);

        // R-type ADD, zero-wait fetch.
        clr_obs();
        cyc(PH_IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
        run(4'd2, 0, 0, 1'b1, tr);
        @(negedge clk); #1;
        lit("r_busy_cycles", obs_busy, 4);
        lit("r_pc_en", obs_pc_en, 1);
        lit("r_reg_write", obs_reg_write, 1);
        lit("r_model_count", int'(model_count), 1);
        repeat (2) cyc(PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);

        // LD with three data-wait cycles.
        clr_obs();
        cyc(PH_IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
        run(4'd0, 0, 3, 1'b1, tr);
        @(negedge clk); #1;
        lit("ld_busy_cycles", obs_busy, 8);
        lit("ld_mem_read", obs_mem_read, 4);
        lit("ld_reg_write", obs_reg_write, 1);
        repeat (2) cyc(PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);

        // LD whose ready arrives on the last allowed MEM cycle.
        clr_obs();
        cyc(PH_IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
        run(4'd0, 0, TMO - 1, 1'b1, tr);
        repeat (2) cyc(PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        lit("ld_edge_mem_read", obs_mem_read, 15);
        lit("ld_edge_no_trap", obs_trap, 0);

        // Back-to-back chain without halting in between.
        clr_obs();
        cyc(PH_IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
        run(4'hB, 0, 0, 1'b0, tr);
        run(4'hC, 1, 0, 1'b0, tr);
        run(4'h1, 0, 0, 1'b0, tr);
        run(4'h3, 2, 0, 1'b0, tr);
        run(4'hD, 0, 0, 1'b1, tr);
        @(negedge clk); #1;
        lit("chain_busy_cycles", obs_busy, 24);
        lit("chain_pc_en", obs_pc_en, 5);
        lit("chain_reg_write", obs_reg_write, 1);
        lit("chain_mem_write", obs_mem_write, 1);
        lit("chain_model_count", int'(model_count), 8);
        repeat (2) cyc(PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);

        // Counter wrap through a run of JMPs, then halt.
        do_reset();
        cyc(PH_IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 255; k++) run(4'hD, 0, 0, 1'b0, tr);
        lit("wrap_model_ff", int'(model_count), 255);
        run(4'hD, 0, 0, 1'b1, tr);
        repeat (2) cyc(PH_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1;
        lit("wrap_count", int'(instr_count), 0);
        lit("halt_busy", int'(busy), 0);

        // Illegal opcodes trap after DECODE; start and halt_req are then ignored.
        for (int m = 0; m < 3; m++) begin
            do_reset();
            clr_obs();
            cyc(PH_IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
            run(ill_ops[m], 0, 0, 1'b0, tr);
            lit("illegal_trapped", int'(tr), 1);
            repeat (4) cyc(PH_TRAP, 1'b1, 1'b1, 1'b1, 1'b1);
            @(negedge clk); #1;
            lit("illegal_cause", int'(trap_cause), 1);
            lit("illegal_pc_en", obs_pc_en, 0);
        end

        // Store that never sees dmem_ready.
        do_reset();
        clr_obs();
        cyc(PH_IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
        run(4'd1, 0, 1000, 1'b0, tr);
        lit("timeout_trapped", int'(tr), 1);
        repeat (5) cyc(PH_TRAP, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        lit("timeout_mem_write", obs_mem_write, 15);
        lit("timeout_cause", int'(trap_cause), 2);
        lit("timeout_trap", int'(trap), 1);

        exp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/risc16_ctrl_seq.md
Name: risc16_ctrl_seq

Overview:
- Multi-cycle control sequencer directly upstream of the risc16 datapath.
- Consumes the datapath's 4-bit opcode and drives every datapath control input (jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write, alu_op).
- Adds state-gated pc_en / ir_load strobes so each instruction spans several cycles with ready/wait handshakes to instruction and data memory.
- Traps on illegal opcodes and on data-memory timeout.

Parameters:
- MEM_TIMEOUT, 15: max cycles in MEM waiting for dmem_ready before trapping (1..255).
- CNT_W, 16: width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching.
- halt_req  in  1  return to IDLE after the current instruction retires.
- opcode  in  4  instr[15:12] from datapath IR.
- imem_ready  in  1  instruction word valid.
- dmem_ready  in  1  data access complete.
- jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write  out  1 each  datapath controls.
- alu_op  out  2  ALU control class.
- ir_load  out  1  latch instruction into IR.
- pc_en  out  1  advance PC (single-cycle pulse).
- busy  out  1  state is not IDLE and not TRAP.
- trap  out  1  sticky error flag.
- trap_cause  out  2  01 illegal opcode; 10 memory timeout; 00 none.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output 0; timeout counter 0; instr_count 0. Reset mid-instruction aborts immediately with no pending strobe.
- All outputs are registered, with no combinational path from any input to any output.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: all strobes 0. start=1 -> FETCH.
- FETCH: ir_load=1 every cycle until imem_ready=1 is sampled, then -> DECODE.
- DECODE: register the decode of opcode; controls hold constant until WB exits.
  - 0000 LD: alu_src=1, mem_to_reg=1, alu_op=10.
  - 0001 ST: alu_src=1, alu_op=10.
  - 0010-1001 R-type: reg_dst=1, alu_op=00.
  - 1011 BEQ: beq=1, alu_op=01.
  - 1100 BNE: bne=1, alu_op=01.
  - 1101 JMP: jump=1.
  - 1010, 1110, 1111: illegal -> TRAP, trap_cause=01.
- EXEC: one cycle. LD/ST -> MEM; all others -> WB.
- MEM:
  - mem_read (LD) or mem_write (ST) is held high until dmem_ready=1 is sampled, then -> WB.
  - The counter increments each MEM cycle. If MEM_TIMEOUT cycles elapse without dmem_ready -> TRAP, trap_cause=10.
  - dmem_ready in the same cycle the counter reaches the limit counts as success.
  - Counter clears on MEM entry.
- WB: one cycle.
  - pc_en=1.
  - reg_write=1 for LD and R-type only.
  - instr_count += 1, wrapping from all-ones to 0.
  - halt_req=1 -> IDLE, else -> FETCH.
  - halt_req is sampled only in WB.
- TRAP: every strobe 0, controls 0, trap=1 and trap_cause held. start and halt_req are ignored; only reset exits.
- Branch outcome is resolved in the datapath (beq/bne gated with zero flag). The sequencer only supplies pc_en.
- Latency with zero-wait memories, counting cycles from FETCH entry to WB inclusive:
  - R-type, branch, JMP: 4.
  - LD/ST: 5 + data wait cycles.
- Strobe contracts:
  - pc_en and reg_write are never high outside WB.
  - mem_read and mem_write are never high outside MEM.
  - No strobe is high in the cycle following WB.

Decomposition:
- Shared package risc16_pkg:
  - opcode constants (OP_LD, OP_ST, OP_ADD..OP_SLT, OP_BEQ, OP_BNE, OP_JMP);
  - alu_op class constants (ALUOP_MEM=10, ALUOP_R=00, ALUOP_BR=01);
  - state encoding;
  - trap_cause codes.
- One sub-module, risc16_decode: purely combinational opcode -> control-bundle plus illegal flag. The sequencer registers its output in DECODE.

Test Plan:
- Reset/idle: rst_n low mid-MEM with mem_write=1 -> all outputs 0 same cycle. After release with start=0 for 10 cycles, busy=0 and instr_count=0.
- R-type: start=1, imem_ready=1, opcode=0010 -> reg_dst=1, alu_op=00. reg_write and pc_en pulse together in cycle 4 exactly once; instr_count=1.
- LD with waits: opcode=0000, dmem_ready delayed 3 cycles -> mem_read high 4 cycles, then WB with reg_write=1, mem_to_reg=1. Total 8 cycles.
- Timeout: opcode=0001, MEM_TIMEOUT=15, dmem_ready=0 -> mem_write high 15 cycles, then trap=1, trap_cause=10, all strobes 0. A later start is ignored.
- Illegal opcode: opcode=1110 -> TRAP after DECODE, trap_cause=01, pc_en never asserted.
- Halt and wrap: instr_count preloaded by running 65535 JMPs (jump=1, reg_write=0), then one more -> count wraps to 0. halt_req=1 during WB -> IDLE next cycle, busy=0.
